// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/jump target selection, misaligned-target trap
// capture and a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned                  DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]        RESET_VECTOR = DATA_WIDTH'(32'h0000_0000),
    parameter logic [DATA_WIDTH-1:0]        TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100),
    parameter int unsigned                  RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] addr_offset,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            jump_type,
    input  logic                  update_pc,
    input  logic                  ras_push,
    input  logic                  ras_pop,
    input  logic                  trap_return,
    output logic [DATA_WIDTH-1:0] pc_current,
    output logic [DATA_WIDTH-1:0] pc_plus_4,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic [DATA_WIDTH-1:0] ras_top,
    output logic                  ras_valid,
    output logic                  trap_pulse,
    output logic [DATA_WIDTH-1:0] trap_epc,
    output logic [DATA_WIDTH-1:0] trap_tval
);

    localparam logic [2:0] JUMP_IF_0 = 3'd1;
    localparam logic [2:0] JUMP_IF_1 = 3'd2;
    localparam logic [2:0] JUMP_JAL  = 3'd3;
    localparam logic [2:0] JUMP_JALR = 3'd4;
    localparam logic [2:0] JUMP_ZERO = 3'd5;

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_trap_pulse;
    logic [DATA_WIDTH-1:0] r_trap_epc;
    logic [DATA_WIDTH-1:0] r_trap_tval;
    logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         r_count;

    logic [DATA_WIDTH-1:0] w_pc_plus_4;
    logic [DATA_WIDTH-1:0] w_branch_tgt;
    logic [DATA_WIDTH-1:0] w_raw_tgt;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic                  w_misaligned;
    logic                  w_trap_taken;
    logic                  w_ras_ok;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic [PW-1:0]         w_ptr_inc;
    logic [PW-1:0]         w_ptr_dec;
    logic [PW-1:0]         w_ptr_d;
    logic [CW-1:0]         w_count_d;
    logic                  w_ras_we;
    logic [PW-1:0]         w_ras_waddr;

    assign w_pc_plus_4  = r_pc + DATA_WIDTH'(4);
    assign w_branch_tgt = r_pc + addr_offset;

    always_comb begin
        w_raw_tgt = w_pc_plus_4;
        case (jump_type)
            JUMP_IF_0: if (!alu_result[0]) w_raw_tgt = w_branch_tgt;
            JUMP_IF_1: if (alu_result[0]) w_raw_tgt = w_branch_tgt;
            JUMP_JAL:  w_raw_tgt = w_branch_tgt;
            JUMP_JALR: w_raw_tgt = {alu_result[DATA_WIDTH-1:1], 1'b0};
            JUMP_ZERO: w_raw_tgt = '0;
            default:   w_raw_tgt = w_pc_plus_4;
        endcase
    end

    assign w_misaligned = (w_raw_tgt[1:0] != 2'b00);

    always_comb begin
        if (trap_return) begin
            w_pc_next = r_trap_epc;
        end else if (w_misaligned) begin
            w_pc_next = TRAP_VECTOR;
        end else begin
            w_pc_next = w_raw_tgt;
        end
    end

    // A trap return or a trap both leave the return-address stack untouched.
    assign w_trap_taken = update_pc && !trap_return && w_misaligned;
    assign w_ras_ok     = update_pc && !trap_return && !w_misaligned;
    assign w_do_push    = w_ras_ok && ras_push;
    assign w_do_pop     = w_ras_ok && ras_pop;

    assign w_ptr_inc = (r_ptr == PTR_MAX) ? '0 : r_ptr + PW'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_MAX : r_ptr - PW'(1);

    // r_ptr indexes the top entry whenever r_count is non-zero; pushing past a full
    // stack advances over the oldest entry.
    always_comb begin
        w_ras_we    = 1'b0;
        w_ras_waddr = r_ptr;
        w_ptr_d     = r_ptr;
        w_count_d   = r_count;
        if (w_do_push && w_do_pop) begin
            w_ras_we    = 1'b1;
            w_ras_waddr = r_ptr;
            if (r_count == '0) begin
                w_count_d = CW'(1);
            end
        end else if (w_do_push) begin
            w_ras_we    = 1'b1;
            w_ras_waddr = w_ptr_inc;
            w_ptr_d     = w_ptr_inc;
            if (r_count != CNT_MAX) begin
                w_count_d = r_count + CW'(1);
            end
        end else if (w_do_pop && (r_count != '0)) begin
            w_ptr_d   = w_ptr_dec;
            w_count_d = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_trap_pulse <= 1'b0;
            r_trap_epc   <= '0;
            r_trap_tval  <= '0;
            r_ptr        <= '0;
            r_count      <= '0;
        end else begin
            r_trap_pulse <= w_trap_taken;
            if (update_pc) begin
                r_pc <= {w_pc_next[DATA_WIDTH-1:2], 2'b00};
            end
            if (w_trap_taken) begin
                r_trap_epc  <= r_pc;
                r_trap_tval <= w_raw_tgt;
            end
            r_ptr   <= w_ptr_d;
            r_count <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ras_we) begin
            r_ras[w_ras_waddr] <= w_pc_plus_4;
        end
    end

    assign pc_current = r_pc;
    assign pc_plus_4  = w_pc_plus_4;
    assign pc_next    = w_pc_next;
    assign ras_valid  = (r_count != '0);
    assign ras_top    = ras_valid ? r_ras[r_ptr] : '0;
    assign trap_pulse = r_trap_pulse;
    assign trap_epc   = r_trap_epc;
    assign trap_tval  = r_trap_tval;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table walked edge by edge, then
// hand-written checks for combinational next-PC priority and async reset mid-trap.
module tb_pc_sequencer;

    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] IF0  = 3'd1;
    localparam logic [2:0] IF1  = 3'd2;
    localparam logic [2:0] JAL  = 3'd3;
    localparam logic [2:0] JALR = 3'd4;
    localparam logic [2:0] ZERO = 3'd5;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_offset;
    logic [31:0] alu_result;
    logic [2:0]  jump_type;
    logic        update_pc;
    logic        ras_push;
    logic        ras_pop;
    logic        trap_return;
    logic [31:0] pc_current;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_next;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic        trap_pulse;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_offset (addr_offset),
        .alu_result  (alu_result),
        .jump_type   (jump_type),
        .update_pc   (update_pc),
        .ras_push    (ras_push),
        .ras_pop     (ras_pop),
        .trap_return (trap_return),
        .pc_current  (pc_current),
        .pc_plus_4   (pc_plus_4),
        .pc_next     (pc_next),
        .ras_top     (ras_top),
        .ras_valid   (ras_valid),
        .trap_pulse  (trap_pulse),
        .trap_epc    (trap_epc),
        .trap_tval   (trap_tval)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  jt;
        logic [31:0] off;
        logic [31:0] alu;
        logic        upd;
        logic        tret;
        logic        push;
        logic        pop;
        logic [31:0] pc;
        logic [31:0] top;
        logic        valid;
        logic        pulse;
        logic [31:0] epc;
        logic [31:0] tval;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] jt, input logic [31:0] off, input logic [31:0] alu,
                       input logic upd, input logic tret, input logic push, input logic pop,
                       input logic [31:0] pc, input logic [31:0] top, input logic valid,
                       input logic pulse, input logic [31:0] epc, input logic [31:0] tval);
        vec_t v;
        v.jt = jt; v.off = off; v.alu = alu; v.upd = upd; v.tret = tret;
        v.push = push; v.pop = pop; v.pc = pc; v.top = top; v.valid = valid;
        v.pulse = pulse; v.epc = epc; v.tval = tval;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] jt, input logic [31:0] off, input logic [31:0] alu,
                         input logic upd, input logic tret, input logic push, input logic pop);
        jump_type = jt; addr_offset = off; alu_result = alu;
        update_pc = upd; trap_return = tret; ras_push = push; ras_pop = pop;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // jt off alu upd tret push pop | pc top valid pulse epc tval
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 0, 32'h4,    32'h0,  0, 0, 32'h0,  32'h0);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 0, 32'h8,    32'h0,  0, 0, 32'h0,  32'h0);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 0, 32'hC,    32'h0,  0, 0, 32'h0,  32'h0);
        add(JAL,  32'h34,       32'h0,   1, 0, 0, 0, 32'h40,   32'h0,  0, 0, 32'h0,  32'h0);
        add(IF1,  32'h20,       32'h1,   1, 0, 0, 0, 32'h60,   32'h0,  0, 0, 32'h0,  32'h0);
        add(JAL,  32'hFFFFFFE0, 32'h0,   1, 0, 0, 0, 32'h40,   32'h0,  0, 0, 32'h0,  32'h0);
        add(IF1,  32'h20,       32'h0,   1, 0, 0, 0, 32'h44,   32'h0,  0, 0, 32'h0,  32'h0);
        add(IF0,  32'h3C,       32'h0,   1, 0, 0, 0, 32'h80,   32'h0,  0, 0, 32'h0,  32'h0);
        add(IF0,  32'h8,        32'h1,   1, 0, 0, 0, 32'h84,   32'h0,  0, 0, 32'h0,  32'h0);
        add(JAL,  32'hFFFFFFFC, 32'h0,   1, 0, 0, 0, 32'h80,   32'h0,  0, 0, 32'h0,  32'h0);
        add(JALR, 32'h0,        32'h203, 1, 0, 0, 0, 32'h100,  32'h0,  0, 1, 32'h80, 32'h202);
        add(SEQ,  32'h0,        32'h0,   1, 1, 0, 0, 32'h80,   32'h0,  0, 0, 32'h80, 32'h202);
        add(JALR, 32'h0,        32'h203, 0, 0, 1, 0, 32'h80,   32'h0,  0, 0, 32'h80, 32'h202);
        add(ZERO, 32'h0,        32'h0,   1, 0, 0, 0, 32'h0,    32'h0,  0, 0, 32'h80, 32'h202);
        add(JAL,  32'h1,        32'h0,   1, 0, 1, 0, 32'h100,  32'h0,  0, 1, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 1, 1, 1, 32'h0,    32'h0,  0, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h4,    32'h4,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h8,    32'h8,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'hC,    32'hC,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h10,   32'h10, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h14,   32'h14, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h18,   32'h10, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h1C,   32'hC,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h20,   32'h8,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h24,   32'h0,  0, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h28,   32'h0,  0, 0, 32'h0,  32'h1);
        add(ZERO, 32'h0,        32'h0,   1, 0, 0, 0, 32'h0,    32'h0,  0, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h4,    32'h4,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 0, 32'h8,    32'h4,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 0, 32'hC,    32'h4,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 0, 32'h10,   32'h10, 1, 0, 32'h0,  32'h1);
        add(JAL,  32'h10,       32'h0,   1, 0, 0, 0, 32'h20,   32'h10, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 1, 32'h24,   32'h24, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h28,   32'h4,  1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h2C,   32'h0,  0, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 1, 1, 32'h30,   32'h30, 1, 0, 32'h0,  32'h1);
        add(SEQ,  32'h0,        32'h0,   1, 0, 0, 1, 32'h34,   32'h0,  0, 0, 32'h0,  32'h1);
        add(JALR, 32'h0,        32'h1001,1, 0, 0, 0, 32'h1000, 32'h0,  0, 0, 32'h0,  32'h1);
        add(3'd7, 32'h40,       32'h0,   1, 0, 0, 0, 32'h1004, 32'h0,  0, 0, 32'h0,  32'h1);
        add(3'd6, 32'h40,       32'h0,   1, 0, 0, 0, 32'h1008, 32'h0,  0, 0, 32'h0,  32'h1);

        rst_n = 1'b0;
        drive(SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset pc_current", pc_current, 32'h0);
        chk("reset trap_pulse", {31'b0, trap_pulse}, 32'h0);
        chk("reset ras_valid", {31'b0, ras_valid}, 32'h0);
        chk("reset ras_top", ras_top, 32'h0);
        chk("reset trap_epc", trap_epc, 32'h0);
        chk("reset trap_tval", trap_tval, 32'h0);
        chk("reset pc_plus_4", pc_plus_4, 32'h4);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].jt, vq[i].off, vq[i].alu, vq[i].upd, vq[i].tret, vq[i].push, vq[i].pop);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc_current", i), pc_current, vq[i].pc);
            chk($sformatf("v%0d ras_top", i), ras_top, vq[i].top);
            chk($sformatf("v%0d ras_valid", i), {31'b0, ras_valid}, {31'b0, vq[i].valid});
            chk($sformatf("v%0d trap_pulse", i), {31'b0, trap_pulse}, {31'b0, vq[i].pulse});
            chk($sformatf("v%0d trap_epc", i), trap_epc, vq[i].epc);
            chk($sformatf("v%0d trap_tval", i), trap_tval, vq[i].tval);
        end

        // Combinational next-PC with update_pc low; pc_current is 0x1008.
        drive(JAL, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("comb pc_next jal", pc_next, 32'h1010);
        chk("comb pc_plus_4", pc_plus_4, 32'h100C);

        drive(SEQ, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("pre-trap push ras_top", ras_top, 32'h100C);
        drive(JALR, 32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("trap2 pc_current", pc_current, 32'h100);
        chk("trap2 trap_pulse", {31'b0, trap_pulse}, 32'h1);
        chk("trap2 trap_epc", trap_epc, 32'h100C);
        chk("trap2 trap_tval", trap_tval, 32'h2);
        chk("trap2 ras_top kept", ras_top, 32'h100C);
        drive(JALR, 32'h0, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("comb trap_return priority", pc_next, 32'h100C);
        trap_return = 1'b0;
        #1;
        chk("comb misaligned to trap vector", pc_next, 32'h100);

        // Asynchronous reset between edges while trap_pulse is high.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst pc_current", pc_current, 32'h0);
        chk("async rst trap_pulse", {31'b0, trap_pulse}, 32'h0);
        chk("async rst ras_valid", {31'b0, ras_valid}, 32'h0);
        chk("async rst trap_epc", trap_epc, 32'h0);
        chk("async rst trap_tval", trap_tval, 32'h0);
        #1;
        rst_n = 1'b1;
        drive(SEQ, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("post-reset first edge pc", pc_current, 32'h4);
        chk("post-reset trap_pulse", {31'b0, trap_pulse}, 32'h0);

        drive(JAL, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("hold pc_current", pc_current, 32'h4);
        chk("hold ras_valid", {31'b0, ras_valid}, 32'h0);
        chk("hold trap_pulse", {31'b0, trap_pulse}, 32'h0);
        chk("hold trap_tval", trap_tval, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
